// File: rtl/coco_mmu_pkg.sv
// Shared definitions for the CoCo DAT memory management unit.
// Holds the register decode addresses, INIT0 bit positions and the
// init sequencer state encoding used by coco_dat_mmu and coco_dat_init.
package coco_mmu_pkg;

  // CPU-visible register addresses
  localparam logic [15:0] AddrInit0  = 16'hFF90;
  localparam logic [15:0] AddrTask   = 16'hFF91;
  localparam logic [15:0] AddrWtask  = 16'hFF92;
  localparam logic [15:0] AddrDatWin = 16'hFFA0;  // eight-entry window $FFA0-$FFA7

  // INIT0 bit positions
  localparam int unsigned Init0MmuEn = 6;
  localparam int unsigned Init0CrmEn = 3;
  localparam int unsigned Init0Start = 0;

  // WTASK read-back bit carrying the sticky lost-write flag
  localparam int unsigned WtaskLostBit = 7;

  // Init sequencer state encoding
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

endpackage

// File: rtl/coco_dat_init.sv
// DAT init sequencer: after reset release (or a start request) walks every DAT
// entry and writes entry[2:0] into it, one entry per E cycle.
// Ports:
//   e         - CPU E clock, state advances on the rising edge
//   _reset    - asynchronous active-low reset (leaves the sequencer in FILL)
//   start     - restart the fill from entry 0 (sampled on the rising edge)
//   busy      - high while filling
//   cnt       - entry currently being written
//   fill_data - data for the current entry
//   fill_we_n - active-low SRAM strobe, low during the E-low half of a fill cycle
module coco_dat_init
  import coco_mmu_pkg::*;
#(
  parameter int unsigned TASK_BITS = 5,
  parameter int unsigned BANK_BITS = 8
) (
  input  logic                   e,
  input  logic                   _reset,
  input  logic                   start,
  output logic                   busy,
  output logic [TASK_BITS+2:0]   cnt,
  output logic [BANK_BITS-1:0]   fill_data,
  output logic                   fill_we_n
);

  logic [0:0]           state_q, state_d;
  logic [TASK_BITS+2:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = StFill;
      cnt_d   = '0;
    end else if (state_q == StFill) begin
      if (&cnt_q) begin
        // last entry written, stop without wrapping
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      state_q <= StFill;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == StFill);
  assign cnt       = cnt_q;
  assign fill_data = {{(BANK_BITS-3){1'b0}}, cnt_q[2:0]};
  // Write in the E-low half so the address from the rising edge has settled;
  // held off entirely while reset is asserted.
  assign fill_we_n = ~(busy & ~e & _reset);

endmodule

// File: rtl/coco_dat_mmu.sv
// CoCo DAT MMU: task-based address translation through an external DAT SRAM.
// CPU registers: $FF90 INIT0, $FF91 TASK, $FF92 WTASK (bit7 = lost-write flag),
// $FFA0-$FFA7 window onto the DAT entries of task WTASK.
// Ports:
//   e, _reset                   - E clock, asynchronous active-low reset
//   address_cpu, r_w_cpu        - CPU bus address and direction (1 = read)
//   data_cpu_in / data_cpu_out  - CPU write data / registered register read data
//   reg_sel                     - address decodes to an MMU register or DAT window
//   address_mem                 - translated physical address
//   address_dat, data_dat_in,
//   data_dat_out, _we_dat       - DAT SRAM interface
//   init_busy                   - init sequencer running
// Build option: define COCO_DAT_CRM_EN to enable the constant RAM mapping of
// $FE00-$FEFF to the all-ones bank (INIT0 bit3).
module coco_dat_mmu
  import coco_mmu_pkg::*;
#(
  parameter int unsigned TASK_BITS = 5,
  parameter int unsigned BANK_BITS = 8
) (
  input  logic                    e,
  input  logic                    _reset,
  input  logic [15:0]             address_cpu,
  input  logic                    r_w_cpu,
  input  logic [7:0]              data_cpu_in,
  output logic [7:0]              data_cpu_out,
  output logic                    reg_sel,
  output logic [BANK_BITS+12:0]   address_mem,
  output logic [TASK_BITS+2:0]    address_dat,
  input  logic [BANK_BITS-1:0]    data_dat_in,
  output logic [BANK_BITS-1:0]    data_dat_out,
  output logic                    _we_dat,
  output logic                    init_busy
);

  logic                 mmu_en_q, crm_en;
  logic [TASK_BITS-1:0] task_q, wtask_q;
  logic                 wr_lost_q;
  logic [7:0]           rdata_q, rd_data;

  logic sel_init0, sel_task, sel_wtask, sel_win, wr;
  logic init0_wr, task_wr, wtask_wr, win_wr, init_start;
  logic [TASK_BITS+2:0] fill_cnt;
  logic [BANK_BITS-1:0] fill_data;
  logic                 fill_we_n;

  assign sel_init0 = (address_cpu == AddrInit0);
  assign sel_task  = (address_cpu == AddrTask);
  assign sel_wtask = (address_cpu == AddrWtask);
  assign sel_win   = (address_cpu[15:3] == AddrDatWin[15:3]);
  assign reg_sel   = sel_init0 | sel_task | sel_wtask | sel_win;

  assign wr         = ~r_w_cpu;
  assign init0_wr   = sel_init0 & wr;
  assign task_wr    = sel_task & wr;
  assign wtask_wr   = sel_wtask & wr;
  assign win_wr     = sel_win & wr;
  assign init_start = init0_wr & data_cpu_in[Init0Start];

  coco_dat_init #(
    .TASK_BITS (TASK_BITS),
    .BANK_BITS (BANK_BITS)
  ) u_init (
    .e         (e),
    ._reset    (_reset),
    .start     (init_start),
    .busy      (init_busy),
    .cnt       (fill_cnt),
    .fill_data (fill_data),
    .fill_we_n (fill_we_n)
  );

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      mmu_en_q  <= 1'b0;
      task_q    <= '0;
      wtask_q   <= '0;
      wr_lost_q <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      // Starting the sequencer always drops translation until software re-enables it
      if (init0_wr) mmu_en_q <= data_cpu_in[Init0MmuEn] & ~data_cpu_in[Init0Start];
      if (task_wr)  task_q   <= data_cpu_in[TASK_BITS-1:0];
      if (wtask_wr) begin
        wtask_q   <= data_cpu_in[TASK_BITS-1:0];
        wr_lost_q <= 1'b0;
      end else if (win_wr && init_busy) begin
        wr_lost_q <= 1'b1;
      end
      if (reg_sel && r_w_cpu) rdata_q <= rd_data;
    end
  end

`ifdef COCO_DAT_CRM_EN
  logic crm_en_q;

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      crm_en_q <= 1'b0;
    end else if (init0_wr) begin
      crm_en_q <= data_cpu_in[Init0CrmEn];
    end
  end

  assign crm_en = crm_en_q;
`else
  assign crm_en = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    if (sel_init0) begin
      rd_data[Init0MmuEn] = mmu_en_q;
      rd_data[Init0CrmEn] = crm_en;
      rd_data[Init0Start] = init_busy;
    end else if (sel_task) begin
      rd_data = 8'(task_q);
    end else if (sel_wtask) begin
      rd_data = 8'(wtask_q);
      rd_data[WtaskLostBit] = wr_lost_q;
    end else if (sel_win) begin
      // DAT contents are in flux while filling
      rd_data = init_busy ? 8'hFF : 8'(data_dat_in);
    end
  end

  assign data_cpu_out = rdata_q;

  always_comb begin
    if (init_busy)    address_dat = fill_cnt;
    else if (sel_win) address_dat = {wtask_q, address_cpu[2:0]};
    else              address_dat = {task_q, address_cpu[15:13]};

    address_mem = {{(BANK_BITS-3){1'b0}}, address_cpu};
    if (mmu_en_q && !init_busy && (address_cpu[15:8] != 8'hFF)) begin
      address_mem = {data_dat_in, address_cpu[12:0]};
`ifdef COCO_DAT_CRM_EN
      if (crm_en && (address_cpu[15:8] == 8'hFE)) begin
        address_mem = {{BANK_BITS{1'b1}}, address_cpu[12:0]};
      end
`endif
    end
  end

  assign data_dat_out = init_busy ? fill_data : data_cpu_in[BANK_BITS-1:0];
  // CPU window writes strobe during E high; writes arriving mid-fill are dropped
  assign _we_dat      = init_busy ? fill_we_n : ~(e & win_wr);

endmodule

// File: doc/coco_dat_mmu.md
COCO_DAT_MMU -- requirements
Module: coco_dat_mmu

Interface
REQ-001 SHALL have parameter TASK_BITS, default 5, number of task-select bits (1..8); DAT depth = 2^(TASK_BITS+3) entries.
REQ-002 SHALL have parameter BANK_BITS, default 8, DAT entry width (4..8); physical address = BANK_BITS+13 bits.
REQ-003 SHALL have port e  input  1  CPU E clock; all state updates on rising edge.
REQ-004 SHALL have port _reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port address_cpu  input  16  CPU address.
REQ-006 SHALL have port r_w_cpu  input  1  1 = read, 0 = write.
REQ-007 SHALL have port data_cpu_in  input  8  CPU write data.
REQ-008 SHALL have port data_cpu_out  output  8  register/DAT read data, valid when reg_sel=1.
REQ-009 SHALL have port reg_sel  output  1  high when address decodes to an MMU register or DAT window.
REQ-010 SHALL have port address_mem  output  BANK_BITS+13  translated physical address.
REQ-011 SHALL have port address_dat  output  TASK_BITS+3  DAT SRAM address.
REQ-012 SHALL have port data_dat_in  input  BANK_BITS  DAT SRAM read data.
REQ-013 SHALL have port data_dat_out  output  BANK_BITS  DAT SRAM write data.
REQ-014 SHALL have port _we_dat  output  1  DAT SRAM write strobe, active low.
REQ-015 SHALL have port init_busy  output  1  high while the init sequencer runs.

Function
REQ-016 Decode: $FF90 INIT0, $FF91 TASK (active task), $FF92 WTASK (window task), $FFA0-$FFA7 DAT window; reg_sel covers exactly these.
REQ-017 INIT0 write: bit6 -> mmu_en, bit3 -> crm_en; bit0=1 starts init sequencer (self-clearing, forces mmu_en=0).
REQ-018 INIT0 read: {0, mmu_en, 0, 0, crm_en, 0, 0, init_busy}.
REQ-019 TASK/WTASK writes capture data_cpu_in[TASK_BITS-1:0]; reads return value zero-extended to 8 bits.
REQ-020 DAT window access: address_dat = {wtask, address_cpu[2:0]}; write data = data_cpu_in[BANK_BITS-1:0]; read returns data_dat_in zero-extended.
REQ-021 DAT window CPU write: _we_dat low only while e high, r_w_cpu=0, window selected and init_busy=0.
REQ-022 Translation, otherwise: address_dat = {task, address_cpu[15:13]}; address_mem = {data_dat_in, address_cpu[12:0]} when mmu_en=1 and address_cpu[15:8] != $FF.
REQ-023 Pass-through (mmu_en=0, $FFxx, or init_busy=1): address_mem = {0, address_cpu[15:0]}.
REQ-024 Sequencer FSM states IDLE -> FILL -> IDLE; FILL entered on reset release or INIT0 bit0 write.
REQ-025 FILL: counter cnt (TASK_BITS+3 bits) starts at 0, address_dat = cnt, data_dat_out = cnt[2:0] zero-extended, _we_dat low while e low; cnt increments each rising edge.
REQ-026 FILL exits to IDLE on the edge after cnt = all-ones (no wrap); total 2^(TASK_BITS+3) cycles.
REQ-027 During FILL: CPU DAT writes are dropped and set sticky flag wr_lost; DAT window reads return $FF.
REQ-028 wr_lost readable at $FF92 bit7, cleared by any WTASK write.
REQ-029 INIT0 bit0 write during FILL restarts cnt at 0.

Reset
REQ-030 _reset low asynchronously: mmu_en=0, crm_en=0, task=0, wtask=0, wr_lost=0, cnt=0, FSM=FILL, _we_dat=1, data_cpu_out=$00.
REQ-031 Reset asserted mid-FILL restarts FILL from cnt=0 after release.

Configuration
REQ-032 Macro COCO_DAT_CRM_EN: when defined, crm_en=1 with mmu_en=1 maps $FE00-$FEFF to address_mem = {all-ones bank, address_cpu[12:0]}, bypassing DAT.
REQ-033 Without COCO_DAT_CRM_EN: INIT0 bit3 writes ignored, reads 0, $FExx translates via DAT.

Structure
REQ-034 Shared package coco_mmu_pkg SHALL hold register addresses ($FF90/$FF91/$FF92/$FFA0), INIT0 bit positions and FSM state encoding.
REQ-035 Init sequencer SHALL be sub-module coco_dat_init (FSM, counter, strobe generation).

Verification
REQ-036 Reset release, TASK_BITS=5 -> init_busy high 256 cycles; entry 0x2B reads back 3.
REQ-037 After init, write $FF92=$01, $FFA2=$3F, $FF91=$01, $FF90=$40; read $4123 -> address_mem=$7E123.
REQ-038 Write $FFA0 during FILL -> no _we_dat pulse, $FF92 reads $80; write $FF92 -> bit7 cleared.
REQ-039 COCO_DAT_CRM_EN defined, $FF90=$48, access $FE10 -> address_mem=$1FFE10; macro undefined -> DAT-mapped.
REQ-040 mmu_en=1, access $FF22 -> address_mem=$0FF22 regardless of DAT contents.
REQ-041 _reset pulsed at cnt=100 -> FILL restarts at 0, completes in 256 cycles.
